// File: rtl/riscy_pkg.sv
// Shared encodings for the riscy32 multi-cycle control path:
// FSM states, opcodes, ALUOp/ALUControl codes, flag indices.
package riscy_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEMADR   = 4'd2,
    ST_MEMREAD  = 4'd3,
    ST_MEMWB    = 4'd4,
    ST_MEMWRITE = 4'd5,
    ST_EXECR    = 4'd6,
    ST_EXECI    = 4'd7,
    ST_ALUWB    = 4'd8,
    ST_BRANCH   = 4'd9,
    ST_JAL      = 4'd10,
    ST_LUI      = 4'd11
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SLL  = 4'h1;
  localparam logic [3:0] ALU_SLT  = 4'h2;
  localparam logic [3:0] ALU_SLTU = 4'h3;
  localparam logic [3:0] ALU_XOR  = 4'h4;
  localparam logic [3:0] ALU_SRL  = 4'h5;
  localparam logic [3:0] ALU_OR   = 4'h6;
  localparam logic [3:0] ALU_AND  = 4'h7;
  localparam logic [3:0] ALU_SUB  = 4'h8;
  localparam logic [3:0] ALU_SRA  = 4'hD;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Immediate format depends only on the opcode, so it is valid in every state.
  function automatic logic [1:0] imm_src(input logic [6:0] op);
    logic [1:0] imm;
    case (op)
      OP_STORE:          imm = 2'b01;
      OP_LUI:            imm = 2'b10;
      OP_JAL, OP_BRANCH: imm = 2'b11;
      default:           imm = 2'b00;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// ALU decoder: maps ALUOp plus funct3/funct7 to the ALUControl encoding.
module mc_alu_dec
  import riscy_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_i,
  input  logic       op5_i,
  output logic [3:0] alu_control_o
);

  always_comb begin
    alu_control_o = ALU_ADD;
    case (alu_op_i)
      ALUOP_ADD: alu_control_o = ALU_ADD;
      ALUOP_SUB: alu_control_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          // addi has no funct7 field, so only R-type may select SUB
          3'b000:  alu_control_o = (op5_i && funct7_i) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_control_o = ALU_SLL;
          3'b010:  alu_control_o = ALU_SLT;
          3'b011:  alu_control_o = ALU_SLTU;
          3'b100:  alu_control_o = ALU_XOR;
          3'b101:  alu_control_o = funct7_i ? ALU_SRA : ALU_SRL;
          3'b110:  alu_control_o = ALU_OR;
          default: alu_control_o = ALU_AND;
        endcase
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle control FSM for riscy32: sequences fetch/decode/execute/mem/writeback.
// Optional feature macro MC_CONTROL_LUI_EN enables the LUI state; otherwise lui is illegal.
module mc_control
  import riscy_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7,
  input  logic [3:0] flags,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [3:0] ALUControl,
  output logic       illegal
);

  localparam logic [3:0] S_FETCH    = ST_FETCH;
  localparam logic [3:0] S_DECODE   = ST_DECODE;
  localparam logic [3:0] S_MEMADR   = ST_MEMADR;
  localparam logic [3:0] S_MEMREAD  = ST_MEMREAD;
  localparam logic [3:0] S_MEMWB    = ST_MEMWB;
  localparam logic [3:0] S_MEMWRITE = ST_MEMWRITE;
  localparam logic [3:0] S_EXECR    = ST_EXECR;
  localparam logic [3:0] S_EXECI    = ST_EXECI;
  localparam logic [3:0] S_ALUWB    = ST_ALUWB;
  localparam logic [3:0] S_BRANCH   = ST_BRANCH;
  localparam logic [3:0] S_JAL      = ST_JAL;
`ifdef MC_CONTROL_LUI_EN
  localparam logic [3:0] S_LUI      = ST_LUI;
`endif

  logic [3:0] state_q, state_d;
  logic       pcw_c, adr_c, mw_c, irw_c, rw_c, ill_c;
  logic [1:0] rsrc_c, srca_c, srcb_c, alu_op_c;

  function automatic logic branch_taken(input logic [2:0] f3, input logic [3:0] fl);
    logic t;
    case (f3)
      3'd0:    t = fl[FLAG_Z];
      3'd1:    t = !fl[FLAG_Z];
      3'd4:    t = fl[FLAG_N] ^ fl[FLAG_V];
      3'd5:    t = !(fl[FLAG_N] ^ fl[FLAG_V]);
      3'd6:    t = !fl[FLAG_C];
      3'd7:    t = fl[FLAG_C];
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    pcw_c    = 1'b0;
    adr_c    = 1'b0;
    mw_c     = 1'b0;
    irw_c    = 1'b0;
    rw_c     = 1'b0;
    ill_c    = 1'b0;
    rsrc_c   = 2'b00;
    srca_c   = 2'b00;
    srcb_c   = 2'b00;
    alu_op_c = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        srcb_c = 2'b10;
        rsrc_c = 2'b10;
        irw_c  = mem_ready;
        pcw_c  = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        srca_c = 2'b01;
        srcb_c = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
`ifdef MC_CONTROL_LUI_EN
          OP_LUI:            state_d = S_LUI;
`endif
          default: begin
            ill_c   = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        srca_c  = 2'b10;
        srcb_c  = 2'b01;
        state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_c = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        rsrc_c  = 2'b01;
        rw_c    = 1'b1;
        state_d = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_c = 1'b1;
        mw_c  = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECR: begin
        srca_c   = 2'b10;
        alu_op_c = ALUOP_FUNCT;
        state_d  = S_ALUWB;
      end
      S_EXECI: begin
        srca_c   = 2'b10;
        srcb_c   = 2'b01;
        alu_op_c = ALUOP_FUNCT;
        state_d  = S_ALUWB;
      end
      S_ALUWB: begin
        rw_c    = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        srca_c   = 2'b10;
        alu_op_c = ALUOP_SUB;
        pcw_c    = branch_taken(funct3, flags);
        state_d  = S_FETCH;
      end
      S_JAL: begin
        srca_c  = 2'b01;
        srcb_c  = 2'b10;
        pcw_c   = 1'b1;
        state_d = S_ALUWB;
      end
`ifdef MC_CONTROL_LUI_EN
      S_LUI: begin
        srca_c  = 2'b11;
        srcb_c  = 2'b01;
        state_d = S_ALUWB;
      end
`endif
      default: state_d = S_FETCH;
    endcase
  end

  mc_alu_dec u_alu_dec (
    .alu_op_i      (alu_op_c),
    .funct3_i      (funct3),
    .funct7_i      (funct7),
    .op5_i         (op[5]),
    .alu_control_o (ALUControl)
  );

  // Strobes are gated by reset so nothing fires while reset is held.
  assign PCWrite   = pcw_c & ~reset;
  assign IRWrite   = irw_c & ~reset;
  assign MemWrite  = mw_c  & ~reset;
  assign RegWrite  = rw_c  & ~reset;
  assign illegal   = ill_c & ~reset;
  assign AdrSrc    = adr_c;
  assign ResultSrc = rsrc_c;
  assign ALUSrcA   = srca_c;
  assign ALUSrcB   = srcb_c;
  assign ImmSrc    = imm_src(op);

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control; honours MC_CONTROL_LUI_EN when defined.
module tb_mc_control;

  localparam int T_FETCH = 0, T_DECODE = 1, T_MEMADR = 2, T_MEMREAD = 3, T_MEMWB = 4,
                 T_MEMWRITE = 5, T_EXECR = 6, T_EXECI = 7, T_ALUWB = 8, T_BRANCH = 9,
                 T_JAL = 10, T_LUI = 11;

  localparam logic [6:0] C_LOAD = 7'b0000011, C_STORE = 7'b0100011, C_R = 7'b0110011,
                         C_I = 7'b0010011, C_BR = 7'b1100011, C_JAL = 7'b1101111,
                         C_LUI = 7'b0110111;

  logic clk = 1'b0;
  logic reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic funct7;
  logic [3:0] flags;
  logic mem_ready;
  logic PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [3:0] ALUControl;

  mc_control dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7(funct7),
    .flags(flags), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .illegal(illegal)
  );

  always #5 clk = ~clk;

  logic [17:0] obs;
  assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal};

  logic [17:0] sb_q[$];
  int n_chk = 0;
  int n_fail = 0;

  function automatic bit lui_on();
`ifdef MC_CONTROL_LUI_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit legal_op(input logic [6:0] o);
    return (o == C_LOAD) || (o == C_STORE) || (o == C_R) || (o == C_I) ||
           (o == C_BR) || (o == C_JAL) || (lui_on() && o == C_LUI);
  endfunction

  // Reference output vector for a given state and inputs.
  function automatic logic [17:0] model(input int st, input logic [6:0] o, input logic [2:0] f3,
                                        input logic f7, input logic [3:0] fl, input logic mr,
                                        input logic rs);
    logic pcw, adr, mw, irw, rw, ill;
    logic [1:0] rsrc, sa, sb, aop, imm;
    logic [3:0] ctl;
    pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; ill = 0;
    rsrc = 0; sa = 0; sb = 0; aop = 0;
    case (st)
      T_FETCH:    begin sb = 2; rsrc = 2; irw = mr; pcw = mr; end
      T_DECODE:   begin sa = 1; sb = 1; ill = !legal_op(o); end
      T_MEMADR:   begin sa = 2; sb = 1; end
      T_MEMREAD:  adr = 1;
      T_MEMWB:    begin rsrc = 1; rw = 1; end
      T_MEMWRITE: begin adr = 1; mw = 1; end
      T_EXECR:    begin sa = 2; aop = 2; end
      T_EXECI:    begin sa = 2; sb = 1; aop = 2; end
      T_ALUWB:    rw = 1;
      T_BRANCH: begin
        sa = 2; aop = 1;
        case (f3)
          0: pcw = fl[2];
          1: pcw = !fl[2];
          4: pcw = fl[3] ^ fl[0];
          5: pcw = !(fl[3] ^ fl[0]);
          6: pcw = !fl[1];
          7: pcw = fl[1];
          default: pcw = 0;
        endcase
      end
      T_JAL:      begin sa = 1; sb = 2; pcw = 1; end
      T_LUI:      begin sa = 3; sb = 1; end
      default:    ;
    endcase
    if (o == C_STORE) imm = 2'b01;
    else if (o == C_LUI) imm = 2'b10;
    else if (o == C_JAL || o == C_BR) imm = 2'b11;
    else imm = 2'b00;
    if (aop == 0) ctl = 4'h0;
    else if (aop == 1) ctl = 4'h8;
    else if (f3 == 3'd0) ctl = (o == C_R && f7) ? 4'h8 : 4'h0;
    else if (f3 == 3'd5) ctl = f7 ? 4'hD : 4'h5;
    else ctl = {1'b0, f3};
    if (rs) begin pcw = 0; irw = 0; mw = 0; rw = 0; ill = 0; end
    return {pcw, adr, mw, irw, rw, rsrc, sa, sb, imm, ctl, ill};
  endfunction

  function automatic int nxt(input int st, input logic [6:0] o, input logic mr);
    case (st)
      T_FETCH:    return mr ? T_DECODE : T_FETCH;
      T_DECODE: begin
        if (o == C_LOAD || o == C_STORE) return T_MEMADR;
        if (o == C_R) return T_EXECR;
        if (o == C_I) return T_EXECI;
        if (o == C_BR) return T_BRANCH;
        if (o == C_JAL) return T_JAL;
        if (lui_on() && o == C_LUI) return T_LUI;
        return T_FETCH;
      end
      T_MEMADR:   return (o == C_LOAD) ? T_MEMREAD : T_MEMWRITE;
      T_MEMREAD:  return mr ? T_MEMWB : T_MEMREAD;
      T_MEMWRITE: return mr ? T_FETCH : T_MEMWRITE;
      T_EXECR, T_EXECI, T_JAL, T_LUI: return T_ALUWB;
      default:    return T_FETCH;
    endcase
  endfunction

  // Drives this cycle's inputs and queues the expected outputs.
  task automatic push_cycle(input int st, input logic mr, input logic [3:0] fl);
    mem_ready = mr;
    flags = fl;
    sb_q.push_back(model(st, op, funct3, funct7, fl, mr, reset));
  endtask

  task automatic test_reset;
    logic [17:0] exp;
    @(posedge clk); #1;
    push_cycle(T_FETCH, 1'b1, 4'h0);
    @(negedge clk);
    exp = sb_q.pop_front();
    n_chk++;
    if (obs !== exp) begin n_fail++; $display("FAIL reset_outs: got %h, expected %h", obs, exp); end
    n_chk++;
    if ({PCWrite, IRWrite} !== 2'b00) begin
      n_fail++; $display("FAIL reset_strobes: got %b, expected 00", {PCWrite, IRWrite});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    push_cycle(T_FETCH, 1'b0, 4'h0);
    @(negedge clk);
    exp = sb_q.pop_front();
    n_chk++;
    if (obs !== exp) begin n_fail++; $display("FAIL reset_release: got %h, expected %h", obs, exp); end
    @(posedge clk); #1;
  endtask

  task automatic test_lw;
    int   st[15] = '{T_FETCH, T_DECODE, T_MEMADR, T_MEMREAD, T_MEMWB,
                     T_FETCH, T_FETCH, T_FETCH, T_DECODE, T_MEMADR, T_MEMREAD, T_MEMREAD,
                     T_MEMREAD, T_MEMWB, T_FETCH};
    logic mr[15] = '{1, 1, 1, 1, 1, 0, 0, 1, 1, 1, 0, 0, 1, 1, 0};
    logic [17:0] exp;
    op = C_LOAD; funct3 = 3'd2; funct7 = 1'b0;
    for (int i = 0; i < 15; i++) begin
      push_cycle(st[i], mr[i], 4'h0);
      @(negedge clk);
      exp = sb_q.pop_front();
      n_chk++;
      if (obs !== exp) begin n_fail++; $display("FAIL lw[%0d]: got %h, expected %h", i, obs, exp); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sw_stall;
    int   st[9] = '{T_FETCH, T_DECODE, T_MEMADR, T_MEMWRITE, T_MEMWRITE, T_MEMWRITE,
                    T_MEMWRITE, T_FETCH, T_FETCH};
    logic mr[9] = '{1, 1, 1, 0, 0, 0, 1, 0, 0};
    logic [17:0] exp;
    int mw_cycles = 0;
    op = C_STORE; funct3 = 3'd2; funct7 = 1'b0;
    for (int i = 0; i < 9; i++) begin
      push_cycle(st[i], mr[i], 4'h0);
      @(negedge clk);
      exp = sb_q.pop_front();
      n_chk++;
      if (obs !== exp) begin n_fail++; $display("FAIL sw[%0d]: got %h, expected %h", i, obs, exp); end
      if (MemWrite === 1'b1) mw_cycles++;
      @(posedge clk); #1;
    end
    n_chk++;
    if (mw_cycles != 4) begin n_fail++; $display("FAIL sw_memwrite_cycles: got %0d, expected 4", mw_cycles); end
  endtask

  task automatic test_alu_ops;
    logic [6:0] ops[8] = '{C_R, C_R, C_R, C_R, C_I, C_I, C_I, C_R};
    logic [2:0] f3s[8] = '{3'd0, 3'd0, 3'd5, 3'd2, 3'd0, 3'd5, 3'd5, 3'd7};
    logic       f7s[8] = '{0, 1, 1, 0, 1, 1, 0, 0};
    logic [3:0] ctl[8] = '{4'h0, 4'h8, 4'hD, 4'h2, 4'h0, 4'hD, 4'h5, 4'h7};
    logic [17:0] exp;
    int st[4];
    for (int k = 0; k < 8; k++) begin
      op = ops[k]; funct3 = f3s[k]; funct7 = f7s[k];
      st = '{T_FETCH, T_DECODE, (ops[k] == C_R) ? T_EXECR : T_EXECI, T_ALUWB};
      for (int i = 0; i < 5; i++) begin
        push_cycle((i < 4) ? st[i] : T_FETCH, i < 4, 4'h0);
        @(negedge clk);
        exp = sb_q.pop_front();
        n_chk++;
        if (obs !== exp) begin n_fail++; $display("FAIL alu%0d[%0d]: got %h, expected %h", k, i, obs, exp); end
        if (i == 2) begin
          n_chk++;
          if (ALUControl !== ctl[k]) begin
            n_fail++; $display("FAIL alu%0d_ctl: got %h, expected %h", k, ALUControl, ctl[k]);
          end
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_branch;
    logic [2:0] f3s[11] = '{0, 1, 4, 5, 6, 7, 2, 3, 0, 7, 5};
    logic [3:0] fls[11] = '{4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0000, 4'b0000,
                            4'b0000, 4'b0100, 4'b0000, 4'b0010, 4'b1001};
    logic       tkn[11] = '{1, 0, 1, 0, 1, 0, 0, 0, 0, 1, 1};
    int   st[4] = '{T_FETCH, T_DECODE, T_BRANCH, T_FETCH};
    logic [17:0] exp;
    op = C_BR; funct7 = 1'b0;
    for (int k = 0; k < 11; k++) begin
      funct3 = f3s[k];
      for (int i = 0; i < 4; i++) begin
        push_cycle(st[i], i < 3, fls[k]);
        @(negedge clk);
        exp = sb_q.pop_front();
        n_chk++;
        if (obs !== exp) begin n_fail++; $display("FAIL br%0d[%0d]: got %h, expected %h", k, i, obs, exp); end
        if (i == 2) begin
          n_chk++;
          if (PCWrite !== tkn[k]) begin
            n_fail++; $display("FAIL br%0d_taken: got %b, expected %b", k, PCWrite, tkn[k]);
          end
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_jal;
    int   st[5] = '{T_FETCH, T_DECODE, T_JAL, T_ALUWB, T_FETCH};
    logic [17:0] exp;
    op = C_JAL; funct3 = 3'd3; funct7 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push_cycle(st[i], i < 4, 4'h0);
      @(negedge clk);
      exp = sb_q.pop_front();
      n_chk++;
      if (obs !== exp) begin n_fail++; $display("FAIL jal[%0d]: got %h, expected %h", i, obs, exp); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal;
    logic [6:0] ops[2] = '{7'b0001111, 7'b1111111};
    int   st[3] = '{T_FETCH, T_DECODE, T_FETCH};
    logic [17:0] exp;
    funct3 = 3'd0; funct7 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      op = ops[k];
      for (int i = 0; i < 3; i++) begin
        push_cycle(st[i], i < 2, 4'h0);
        @(negedge clk);
        exp = sb_q.pop_front();
        n_chk++;
        if (obs !== exp) begin n_fail++; $display("FAIL ill%0d[%0d]: got %h, expected %h", k, i, obs, exp); end
        n_chk++;
        if (illegal !== (i == 1)) begin
          n_fail++; $display("FAIL ill%0d_pulse[%0d]: got %b, expected %b", k, i, illegal, (i == 1));
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_lui;
`ifdef MC_CONTROL_LUI_EN
    int   st[5] = '{T_FETCH, T_DECODE, T_LUI, T_ALUWB, T_FETCH};
    logic mr[5] = '{1, 1, 1, 1, 0};
`else
    int   st[5] = '{T_FETCH, T_DECODE, T_FETCH, T_FETCH, T_FETCH};
    logic mr[5] = '{1, 1, 0, 0, 0};
`endif
    logic [17:0] exp;
    op = C_LUI; funct3 = 3'd1; funct7 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push_cycle(st[i], mr[i], 4'h0);
      @(negedge clk);
      exp = sb_q.pop_front();
      n_chk++;
      if (obs !== exp) begin n_fail++; $display("FAIL lui[%0d]: got %h, expected %h", i, obs, exp); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_memwrite;
    int   st[4] = '{T_FETCH, T_DECODE, T_MEMADR, T_MEMWRITE};
    logic mr[4] = '{1, 1, 1, 0};
    logic [17:0] exp;
    op = C_STORE; funct3 = 3'd2; funct7 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_cycle(st[i], mr[i], 4'h0);
      @(negedge clk);
      exp = sb_q.pop_front();
      n_chk++;
      if (obs !== exp) begin n_fail++; $display("FAIL rstmw[%0d]: got %h, expected %h", i, obs, exp); end
      @(posedge clk); #1;
    end
    #2;
    reset = 1'b1;
    push_cycle(T_FETCH, 1'b0, 4'h0);
    #1;
    exp = sb_q.pop_front();
    n_chk++;
    if (obs !== exp) begin n_fail++; $display("FAIL rstmw_async: got %h, expected %h", obs, exp); end
    n_chk++;
    if (MemWrite !== 1'b0) begin n_fail++; $display("FAIL rstmw_memwrite: got %b, expected 0", MemWrite); end
    push_cycle(T_FETCH, 1'b1, 4'h0);
    @(negedge clk);
    exp = sb_q.pop_front();
    n_chk++;
    if (obs !== exp) begin n_fail++; $display("FAIL rstmw_hold: got %h, expected %h", obs, exp); end
    @(posedge clk); #1;
    reset = 1'b0;
    push_cycle(T_FETCH, 1'b0, 4'h0);
    @(negedge clk);
    exp = sb_q.pop_front();
    n_chk++;
    if (obs !== exp) begin n_fail++; $display("FAIL rstmw_release: got %h, expected %h", obs, exp); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    logic [6:0] ops[9] = '{C_LOAD, C_STORE, C_R, C_I, C_BR, C_JAL, C_LUI, 7'b0001111, 7'b0000000};
    logic [17:0] exp;
    logic mr;
    int st = T_FETCH;
    for (int c = 0; c < 400; c++) begin
      if (st == T_FETCH) begin
        op = ops[$urandom_range(0, 8)];
        funct3 = 3'($urandom_range(0, 7));
        funct7 = 1'($urandom_range(0, 1));
      end
      mr = ($urandom_range(0, 3) != 0);
      push_cycle(st, mr, 4'($urandom_range(0, 15)));
      @(negedge clk);
      exp = sb_q.pop_front();
      n_chk++;
      if (obs !== exp) begin
        n_fail++; $display("FAIL b2b[%0d] st%0d op%b: got %h, expected %h", c, st, op, obs, exp);
      end
      st = nxt(st, op, mr);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    op = 7'd0; funct3 = 3'd0; funct7 = 1'b0; flags = 4'h0; mem_ready = 1'b1;
    test_reset;
    test_lw;
    test_sw_stall;
    test_alu_ops;
    test_branch;
    test_jal;
    test_illegal;
    test_lui;
    test_reset_mid_memwrite;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
